// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its arbiter front end: ALU opcodes,
// arbiter FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXEC    = 3'd1;
    localparam logic [2:0] ST_MSTART  = 3'd2;
    localparam logic [2:0] ST_MSETTLE = 3'd3;
    localparam logic [2:0] ST_MWAIT   = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    function automatic logic is_multi_cycle(input logic [2:0] op);
        return op == OP_MOD;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans req starting at ptr and wraps, returning the first
// set requester as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    localparam int KW = IDW + 1;

    logic [KW-1:0]  k_ext;
    logic [IDW-1:0] k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        k_ext = '0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k_ext = {1'b0, ptr} + KW'(i);
            if (k_ext >= KW'(N)) begin
                k_ext = k_ext - KW'(N);
            end
            k = k_ext[IDW-1:0];
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between NUM_REQ requesters: round-robin grant, registered
// operands, single-cycle and MOD start/done sequencing. Optional MOD watchdog: ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]      req_op,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_err,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic                      alu_start,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_op,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_done
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("alu_arbiter: TIMEOUT_CYC must be at least 2");
    end

    logic [2:0]         state;
    logic [IDW-1:0]     ptr_q;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic               grant;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [2:0]         sel_op;
    logic               to_hit;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // alu_done must be high so a MOD still running inside the alu (e.g. after reset) blocks issue.
    assign grant     = (state == ST_IDLE) && alu_done && gnt_any && !reset;
    assign req_ready = grant ? gnt : '0;
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign alu_start = (state == ST_MSTART);

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset || !((state == ST_MSETTLE) || (state == ST_MWAIT))) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_op  <= sel_op;
                        rsp_id  <= gnt_idx;
                        rsp_err <= 1'b0;
                        state   <= is_multi_cycle(sel_op) ? ST_MSTART : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    state      <= ST_RESP;
                end
                ST_MSTART:  state <= ST_MSETTLE;
                // done may still show the pre-start idle level here, so it is not looked at.
                ST_MSETTLE: state <= ST_MWAIT;
                ST_MWAIT: begin
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        state      <= ST_RESP;
                    end else if (to_hit) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        ptr_q <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + IDW'(1);
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural alu (configurable MOD latency and a
// stuck-done stub). Build with ALU_ARB_TIMEOUT_EN defined to cover the watchdog.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int IDW     = 1;
    localparam int SBW     = IDW + DATA_W;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_a = '0;
    logic [NUM_REQ*DATA_W-1:0] req_b = '0;
    logic [NUM_REQ*3-1:0]      req_op = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [IDW-1:0]            rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_err;
    logic                      rsp_ready = 1'b1;
    logic                      busy;
    logic                      alu_start;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [2:0]                alu_op;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_done;

    int n_pass  = 0;
    int n_total = 0;
    logic [SBW-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDW(IDW), .TIMEOUT_CYC(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_done   (alu_done)
    );

    function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return (b == 0) ? '0 : a % b;
        endcase
    endfunction

    // Behavioural alu: MOD latches operands on start and finishes mod_lat cycles later.
    logic              mod_busy  = 1'b0;
    int                mod_cnt   = 0;
    int                mod_lat   = 1;
    logic              stub_hold = 1'b0;
    logic [DATA_W-1:0] mod_a     = '0;
    logic [DATA_W-1:0] mod_b     = '0;
    logic [DATA_W-1:0] mod_res   = '0;

    always @(posedge clk) begin
        if (mod_busy) begin
            mod_cnt <= mod_cnt - 1;
            if (mod_cnt <= 1) begin
                mod_busy <= 1'b0;
                mod_res  <= alu_fn(OP_MOD, mod_a, mod_b);
            end
        end else if (alu_start) begin
            mod_busy <= 1'b1;
            mod_cnt  <= mod_lat;
            mod_a    <= alu_a;
            mod_b    <= alu_b;
        end
    end

    assign alu_done   = !mod_busy && !stub_hold;
    assign alu_result = (alu_op == OP_MOD) ? mod_res : alu_fn(alu_op, alu_a, alu_b);

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input logic [2:0] op, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b);
        req_valid[id]              = 1'b1;
        req_a[id*DATA_W +: DATA_W] = a;
        req_b[id*DATA_W +: DATA_W] = b;
        req_op[id*3 +: 3]          = op;
    endtask

    task automatic push_exp(input int id);
        exp_q.push_back({IDW'(id), alu_fn(req_op[id*3 +: 3], req_a[id*DATA_W +: DATA_W],
                                          req_b[id*DATA_W +: DATA_W])});
    endtask

    task automatic pop_exp(output logic [SBW-1:0] e, output bit ok);
        ok = (exp_q.size() != 0);
        e  = ok ? exp_q.pop_front() : '0;
    endtask

    task automatic wait_grant(output int id, output bit ok);
        id = -1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    id = i;
                    ok = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_rsp(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_total++;
        if ({busy, rsp_valid, alu_start, req_ready, rsp_id, rsp_result, rsp_err, alu_a, alu_b, alu_op} !== '0)
            $display("FAIL reset_outputs: got busy=%b rsp_valid=%b start=%b ready=%b a=%h b=%h expected all 0",
                     busy, rsp_valid, alu_start, req_ready, alu_a, alu_b);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_mod_start();
        int id, starts;
        bit ok, okp;
        logic [SBW-1:0] e;
        mod_lat = 3;
        @(posedge clk);
        #1 set_req(0, OP_MOD, 32'd27, 32'd25);
        wait_grant(id, ok);
        n_total++;
        if (!ok || id !== 0) $display("FAIL t1_grant: got id %0d (seen %b) expected 0", id, ok);
        else n_pass++;
        if (ok) push_exp(id);
        @(posedge clk);
        #1 req_valid = '0;
        starts = 0;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (alu_start) starts++;
            if (rsp_valid) ok = 1'b1;
        end
        n_total++;
        if (starts !== 1) $display("FAIL t1_start_pulse: got %0d cycles expected 1", starts);
        else n_pass++;
        pop_exp(e, okp);
        n_total++;
        if (!ok || !okp || {rsp_id, rsp_result} !== e || rsp_result !== 32'd2)
            $display("FAIL t1_mod_rsp: got id %0d result %h (valid %b) expected id 0 result 2", rsp_id, rsp_result, ok);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mod_then_add();
        int id, cyc;
        bit ok, okp;
        logic [SBW-1:0] e;
        mod_lat = 2;
        set_req(1, OP_MOD, 32'd101, 32'd34);
        wait_grant(id, ok);
        n_total++;
        if (!ok || id !== 1) $display("FAIL t2_grant_mod: got id %0d expected 1", id);
        else n_pass++;
        if (ok) push_exp(id);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(ok, cyc);
        pop_exp(e, okp);
        n_total++;
        if (!ok || !okp || {rsp_id, rsp_result} !== e || rsp_result !== 32'd33)
            $display("FAIL t2_mod_rsp: got id %0d result %h expected id 1 result 33", rsp_id, rsp_result);
        else n_pass++;
        @(posedge clk);
        #1 set_req(0, OP_ADD, 32'd123, 32'd6);
        wait_grant(id, ok);
        if (ok) push_exp(id);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(ok, cyc);
        n_total++;
        if (!ok || cyc !== 2) $display("FAIL t2_add_latency: got %0d cycles expected 2", cyc);
        else n_pass++;
        pop_exp(e, okp);
        n_total++;
        if (!okp || {rsp_id, rsp_result} !== e || rsp_result !== 32'd129)
            $display("FAIL t2_add_rsp: got id %0d result %h expected id 0 result 129", rsp_id, rsp_result);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int id, cyc;
        bit ok, okp;
        logic [SBW-1:0] e;
        do_reset();
        set_req(0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        set_req(1, OP_OR, 32'h1200_0001, 32'h0000_8000);
        for (int k = 0; k < 4; k++) begin
            wait_grant(id, ok);
            n_total++;
            if (!ok || id !== (k % 2)) $display("FAIL t3_order_%0d: got id %0d expected %0d", k, id, k % 2);
            else n_pass++;
            if (ok) push_exp(id);
            @(posedge clk);
            #1;
            if (k == 3) req_valid = '0;
            wait_rsp(ok, cyc);
            pop_exp(e, okp);
            n_total++;
            if (!ok || !okp || {rsp_id, rsp_result} !== e)
                $display("FAIL t3_rsp_%0d: got id %0d result %h expected id %0d result %h",
                         k, rsp_id, rsp_result, e[SBW-1 -: IDW], e[DATA_W-1:0]);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int id, cyc;
        bit ok, okp, stall_ok;
        logic [SBW-1:0] e;
        rsp_ready = 1'b0;
        set_req(0, OP_SUB, 32'd2, 32'd4);
        wait_grant(id, ok);
        n_total++;
        if (!ok || id !== 0) $display("FAIL t4_grant: got id %0d expected 0", id);
        else n_pass++;
        if (ok) push_exp(id);
        @(posedge clk);
        #1 req_valid = '0;
        set_req(1, OP_ADD, 32'd7, 32'd8);
        wait_rsp(ok, cyc);
        stall_ok = ok;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFF_FFFE || rsp_id !== 1'b0 || req_ready !== '0)
                stall_ok = 1'b0;
        end
        n_total++;
        if (!stall_ok)
            $display("FAIL t4_hold: got valid %b id %0d result %h ready %b expected 1 0 fffffffe 00",
                     rsp_valid, rsp_id, rsp_result, req_ready);
        else n_pass++;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        pop_exp(e, okp);
        n_total++;
        if (!okp || rsp_valid !== 1'b1 || {rsp_id, rsp_result} !== e)
            $display("FAIL t4_sub_rsp: got id %0d result %h expected id 0 result fffffffe", rsp_id, rsp_result);
        else n_pass++;
        wait_grant(id, ok);
        n_total++;
        if (!ok || id !== 1) $display("FAIL t4_next_grant: got id %0d expected 1", id);
        else n_pass++;
        if (ok) push_exp(id);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(ok, cyc);
        pop_exp(e, okp);
        n_total++;
        if (!ok || !okp || {rsp_id, rsp_result} !== e)
            $display("FAIL t4_add_rsp: got id %0d result %h expected id 1 result 15", rsp_id, rsp_result);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mwait();
        int id, cyc, waited;
        bit ok, okp, quiet;
        logic [SBW-1:0] e;
        mod_lat = 10;
        set_req(0, OP_MOD, 32'd50, 32'd7);
        wait_grant(id, ok);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        set_req(0, OP_ADD, 32'd5, 32'd6);
        @(posedge clk);
        #1;
        n_total++;
        if ({busy, rsp_valid, alu_start, req_ready, rsp_id, rsp_result, rsp_err, alu_a, alu_b, alu_op} !== '0)
            $display("FAIL t5_reset_outputs: got busy=%b start=%b ready=%b a=%h b=%h op=%h expected all 0",
                     busy, alu_start, req_ready, alu_a, alu_b, alu_op);
        else n_pass++;
        reset = 1'b0;
        exp_q.delete();
        quiet  = 1'b1;
        waited = 0;
        ok     = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (alu_done) ok = 1'b1;
            else begin
                waited++;
                if (req_ready !== '0 || rsp_valid !== 1'b0) quiet = 1'b0;
            end
        end
        n_total++;
        if (!quiet || !ok || waited == 0)
            $display("FAIL t5_blocked: got quiet %b done %b waited %0d expected blocked until done", quiet, ok, waited);
        else n_pass++;
        wait_grant(id, ok);
        if (ok) push_exp(id);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(ok, cyc);
        pop_exp(e, okp);
        n_total++;
        if (!ok || !okp || {rsp_id, rsp_result} !== e || rsp_result !== 32'd11)
            $display("FAIL t5_rsp: got id %0d result %h expected id 0 result 11", rsp_id, rsp_result);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int id, cyc;
        bit ok;
        mod_lat   = 1;
        stub_hold = 1'b1;
        @(posedge clk);
        #1 set_req(0, OP_MOD, 32'd9, 32'd4);
        stub_hold = 1'b0;
        wait_grant(id, ok);
        @(posedge clk);
        #1 req_valid = '0;
        stub_hold = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
        wait_rsp(ok, cyc);
        n_total++;
        if (!ok || rsp_err !== 1'b1 || rsp_result !== '0 || rsp_id !== 1'b0)
            $display("FAIL t6_timeout_rsp: got valid %b err %b result %h expected 1 1 0", ok, rsp_err, rsp_result);
        else n_pass++;
        n_total++;
        if (cyc < 64 || cyc > 68) $display("FAIL t6_timeout_time: got %0d cycles expected 64..68", cyc);
        else n_pass++;
        @(posedge clk);
        #1;
`else
        ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        n_total++;
        if (!ok || busy !== 1'b1) $display("FAIL t6_no_timeout: got rsp seen %b busy %b expected 0 1", !ok, busy);
        else n_pass++;
`endif
        stub_hold = 1'b0;
        do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mod_start();
        test_mod_then_add();
        test_round_robin();
        test_backpressure();
        test_reset_mwait();
        test_timeout();
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
